// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller slice.
// Imported by the top level and the priority selector.
package int_ctrl_pkg;

  localparam int DEF_N_SRC = 4;

  localparam int SRC_TIMER = 0;
  localparam int SRC_EXT   = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/int_prio_sel.sv
// Combinational winner picker: lowest eligible index, or a round-robin
// search starting just after the last granted source.
module int_prio_sel
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] eligible,
  input  logic [ID_W-1:0]  last_grant,
  input  logic             mode,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  int                 start;
  logic [2*N_SRC-1:0] dbl;
  logic [N_SRC-1:0]   rot;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    valid = 1'b0;
    id    = '0;
    start = mode ? (int'(last_grant) + 1) % N_SRC : 0;
    // Rotating the request vector turns the wrap-around search into a lowest-bit search.
    dbl   = {eligible, eligible} >> start;
    rot   = dbl[N_SRC-1:0];
    for (int k = 0; k < N_SRC; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        id    = ID_W'((start + k) % N_SRC);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronise and edge-capture sources, mask, arbitrate,
// and hand one interrupt at a time to the CPU with a take/done handshake.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int               N_SRC       = DEF_N_SRC,
  parameter int               ID_W        = $clog2(N_SRC),
  parameter bit               PRIO_RR     = 1'b0,
  parameter int               SYNC_STAGES = 2,
  parameter logic [N_SRC-1:0] EN_RESET    = '1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_SRC-1:0] src_int,
  output logic [N_SRC-1:0] src_ack,
  input  logic             en_we,
  input  logic [N_SRC-1:0] en_wdata,
  output logic [N_SRC-1:0] en_mask,
  output logic [N_SRC-1:0] pending,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_take,
  input  logic             irq_done,
  output logic             in_service
);

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] id_onehot;
  logic [N_SRC-1:0] claim;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  win_id;
  logic             win_valid;
  logic             offer_ok;
  logic             take_fire;
  state_e           state;

  for (genvar i = 0; i < N_SRC; i++) begin : g_sync
    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        chain <= '0;
        prev  <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge value.
        chain <= {chain[SYNC_STAGES-2:0], src_int[i]};
        prev  <= chain[SYNC_STAGES-1];
      end
    end

    assign rise[i] = chain[SYNC_STAGES-1] & ~prev;
  end

  assign eligible  = pending & en_mask;
  assign offer_ok  = eligible[irq_id];
  assign take_fire = (state == OFFER) && offer_ok && irq_take;
  assign id_onehot = N_SRC'(1) << irq_id;
  assign claim     = take_fire ? id_onehot : '0;

  // A rise arriving on the claim edge is ORed in after the clear, so it survives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= '0;
      en_mask <= EN_RESET;
    end else begin
      pending <= (pending & ~claim) | rise;
      if (en_we) en_mask <= en_wdata;
    end
  end

  int_prio_sel #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_sel (
    .eligible   (eligible),
    .last_grant (last_grant),
    .mode       (PRIO_RR),
    .valid      (win_valid),
    .id         (win_id)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      irq        <= 1'b0;
      irq_id     <= '0;
      in_service <= 1'b0;
      src_ack    <= '0;
      last_grant <= ID_W'(N_SRC - 1);
    end else begin
      src_ack <= '0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            irq_id <= win_id;
            irq    <= 1'b1;
            state  <= OFFER;
          end
        end
        OFFER: begin
          // The offer is frozen; only masking the offered source withdraws it.
          if (!offer_ok) begin
            irq   <= 1'b0;
            state <= IDLE;
          end else if (take_fire) begin
            src_ack    <= id_onehot;
            irq        <= 1'b0;
            in_service <= 1'b1;
            state      <= SERVICE;
            if (PRIO_RR) last_grant <= irq_id;
          end
        end
        SERVICE: begin
          if (irq_done) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Runs a fixed-priority and a round-robin int_ctrl side by side against a
// spec-level reference model, with directed scenarios then random traffic.
module tb_int_ctrl;

  localparam int M_IDLE    = 0;
  localparam int M_OFFER   = 1;
  localparam int M_SERVICE = 2;

  logic       clk  = 1'b0;
  logic       rstn = 1'b1;
  logic [3:0] src  = '0;
  logic       we   = 1'b0;
  logic [3:0] wdata = '0;
  logic       take = 1'b0;
  logic       done = 1'b0;

  logic [1:0][3:0] ack_o, en_o, pend_o;
  logic [1:0][1:0] id_o;
  logic [1:0]      irq_o, svc_o;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state, index 0 = fixed priority, 1 = round-robin.
  int         m_st   [2];
  logic [3:0] m_pend [2];
  logic [3:0] m_mask [2];
  logic [3:0] m_ack  [2];
  logic       m_irq  [2];
  logic       m_svc  [2];
  logic [1:0] m_id   [2];
  logic [1:0] m_lg   [2];
  logic [3:0] smp    [3];

  always #5 clk = ~clk;

  int_ctrl #(.PRIO_RR(1'b0)) dut_fix (
    .clk(clk), .rstn(rstn), .src_int(src), .src_ack(ack_o[0]),
    .en_we(we), .en_wdata(wdata), .en_mask(en_o[0]), .pending(pend_o[0]),
    .irq(irq_o[0]), .irq_id(id_o[0]), .irq_take(take), .irq_done(done),
    .in_service(svc_o[0])
  );

  int_ctrl #(.PRIO_RR(1'b1)) dut_rr (
    .clk(clk), .rstn(rstn), .src_int(src), .src_ack(ack_o[1]),
    .en_we(we), .en_wdata(wdata), .en_mask(en_o[1]), .pending(pend_o[1]),
    .irq(irq_o[1]), .irq_id(id_o[1]), .irq_take(take), .irq_done(done),
    .in_service(svc_o[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  function automatic logic [1:0] pick(input logic [3:0] e, input logic [1:0] lg, input bit rr);
    int s;
    s = rr ? (int'(lg) + 1) % 4 : 0;
    for (int k = 0; k < 4; k++) begin
      if (e[(s + k) % 4]) return 2'((s + k) % 4);
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_st[m] = M_IDLE; m_pend[m] = '0; m_mask[m] = 4'hF; m_ack[m] = '0;
      m_irq[m] = 1'b0;  m_svc[m] = 1'b0; m_id[m] = '0;   m_lg[m] = 2'd3;
    end
    for (int j = 0; j < 3; j++) smp[j] = '0;
  endtask

  // One clock edge of the spec: a rise is the synchronised level two edges back
  // being high while it was low three edges back.
  task automatic model_step();
    logic [3:0] rise, elig;
    rise = smp[1] & ~smp[2];
    for (int m = 0; m < 2; m++) begin
      elig     = m_pend[m] & m_mask[m];
      m_ack[m] = '0;
      case (m_st[m])
        M_IDLE: if (elig != 0) begin
          m_id[m] = pick(elig, m_lg[m], m == 1); m_irq[m] = 1'b1; m_st[m] = M_OFFER;
        end
        M_OFFER: if (!elig[m_id[m]]) begin
          m_irq[m] = 1'b0; m_st[m] = M_IDLE;
        end else if (take) begin
          m_pend[m][m_id[m]] = 1'b0; m_ack[m][m_id[m]] = 1'b1;
          m_irq[m] = 1'b0; m_svc[m] = 1'b1; m_st[m] = M_SERVICE;
          if (m == 1) m_lg[m] = m_id[m];
        end
        default: if (done) begin
          m_svc[m] = 1'b0; m_st[m] = M_IDLE;
        end
      endcase
      m_pend[m] = m_pend[m] | rise;
      if (we) m_mask[m] = wdata;
    end
    smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = src;
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      check(m ? "irq_r"  : "irq_f",  32'(irq_o[m]),  32'(m_irq[m]));
      check(m ? "id_r"   : "id_f",   32'(id_o[m]),   32'(m_id[m]));
      check(m ? "svc_r"  : "svc_f",  32'(svc_o[m]),  32'(m_svc[m]));
      check(m ? "ack_r"  : "ack_f",  32'(ack_o[m]),  32'(m_ack[m]));
      check(m ? "pend_r" : "pend_f", 32'(pend_o[m]), 32'(m_pend[m]));
      check(m ? "en_r"   : "en_f",   32'(en_o[m]),   32'(m_mask[m]));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    src = '0; we = 1'b0; wdata = '0; take = 1'b0; done = 1'b0;
    model_reset();
    #2;
    compare_all();
    check("rst_en",  32'(en_o[0]),  32'hF);
    check("rst_svc", 32'(svc_o[0]), 32'h0);
    check("rst_ack", 32'(ack_o[0]), 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic wait_offer(input int inst, output logic [1:0] gid);
    int n = 0;
    while (!irq_o[inst] && n < 30) begin
      cycle();
      n++;
    end
    check("offer_wait", 32'(irq_o[inst]), 32'h1);
    gid = id_o[inst];
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] gid;
    logic [1:0] rr_exp [5];
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    #1;
    do_reset();

    // Single timer: offer visible after the fourth edge, not the third.
    src = 4'b0001;
    repeat (3) cycle();
    check("lat_early", 32'(irq_o[0]), 32'h0);
    cycle();
    check("lat_irq", 32'(irq_o[0]), 32'h1);
    check("lat_id",  32'(id_o[0]),  32'h0);
    cycle();
    take = 1'b1; cycle(); take = 1'b0;
    check("t_ack",  32'(ack_o[0]),  32'h1);
    check("t_pend", 32'(pend_o[0]), 32'h0);
    check("t_svc",  32'(svc_o[0]),  32'h1);
    cycle();
    check("t_ack1", 32'(ack_o[0]), 32'h0);
    done = 1'b1; cycle(); done = 1'b0;
    check("t_done", 32'(svc_o[0]), 32'h0);
    cycle();
    check("t_noirq", 32'(irq_o[0]), 32'h0);

    // Fixed-priority collision, with a higher-priority arrival during service.
    src = 4'b1010;
    repeat (4) cycle();
    check("col_id1", 32'(id_o[0]), 32'h1);
    take = 1'b1; cycle(); take = 1'b0;
    src = 4'b1011;
    repeat (5) cycle();
    check("col_nonest", 32'(irq_o[0]),  32'h0);
    check("col_pend",   32'(pend_o[0]), 32'h9);
    done = 1'b1; cycle(); done = 1'b0;
    cycle();
    check("col_id0", 32'(id_o[0]), 32'h0);
    take = 1'b1; cycle(); take = 1'b0;
    done = 1'b1; cycle(); done = 1'b0;
    cycle();
    check("col_id3", 32'(id_o[0]), 32'h3);
    take = 1'b1; cycle(); take = 1'b0;
    done = 1'b1; cycle(); done = 1'b0;

    // Round-robin order with re-raised sources.
    do_reset();
    src = 4'hF;
    for (int g = 0; g < 5; g++) begin
      wait_offer(1, gid);
      check("rr_order", 32'(gid), 32'(rr_exp[g]));
      take = 1'b1; cycle(); take = 1'b0;
      src[gid] = 1'b0;
      done = 1'b1; cycle(); done = 1'b0;
      cycle();
      src[gid] = 1'b1;
    end

    // Masking, withdraw, and ignored handshake inputs.
    do_reset();
    we = 1'b1; wdata = 4'b1101; cycle(); we = 1'b0;
    src = 4'b0010;
    repeat (6) cycle();
    check("m_noirq", 32'(irq_o[0]),  32'h0);
    check("m_pend",  32'(pend_o[0]), 32'h2);
    we = 1'b1; wdata = 4'hF; cycle(); we = 1'b0;
    cycle();
    check("m_irq", 32'(irq_o[0]), 32'h1);
    check("m_id",  32'(id_o[0]),  32'h1);
    done = 1'b1; cycle(); done = 1'b0;
    check("m_done_ign", 32'(irq_o[0]), 32'h1);
    we = 1'b1; wdata = 4'b1101; cycle(); we = 1'b0;
    check("m_hold", 32'(irq_o[0]), 32'h1);
    cycle();
    check("m_wdraw", 32'(irq_o[0]),  32'h0);
    check("m_keep",  32'(pend_o[0]), 32'h2);
    we = 1'b1; wdata = 4'hF; cycle(); we = 1'b0;
    cycle();
    take = 1'b1; done = 1'b1; cycle(); take = 1'b0; done = 1'b0;
    check("m_td_svc", 32'(svc_o[0]), 32'h1);
    check("m_td_ack", 32'(ack_o[0]), 32'h2);
    take = 1'b1; cycle(); take = 1'b0;
    check("m_tk_svc", 32'(svc_o[0]), 32'h1);
    check("m_tk_ack", 32'(ack_o[0]), 32'h0);
    done = 1'b1; cycle(); done = 1'b0;
    check("m_fin", 32'(svc_o[0]), 32'h0);
    take = 1'b1; cycle(); take = 1'b0;
    check("m_idle_ack", 32'(ack_o[0]), 32'h0);

    // Rise coinciding with its own claim keeps pending set.
    do_reset();
    we = 1'b1; wdata = 4'b0101; cycle(); we = 1'b0;
    src = 4'b0001;
    repeat (3) cycle();
    src = 4'b0000;
    cycle();
    check("sw_irq", 32'(irq_o[0]), 32'h1);
    src = 4'b0001;
    repeat (2) cycle();
    take = 1'b1; cycle(); take = 1'b0;
    check("sw_pend", 32'(pend_o[0]), 32'h1);
    check("sw_ack",  32'(ack_o[0]),  32'h1);
    check("sw_svc",  32'(svc_o[0]),  32'h1);

    // Reset in SERVICE with an ack in flight and a non-default mask.
    do_reset();

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(9) == 0) src[b] = ~src[b];
      end
      we    = ($urandom_range(31) == 0);
      wdata = ($urandom_range(1) != 0) ? 4'hF : 4'($urandom);
      take  = ($urandom_range(2) == 0);
      done  = ($urandom_range(3) == 0);
      if ($urandom_range(499) == 0) do_reset();
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
